axis_peak_bin_detector: RTL and testbench

Per-frame peak detector on the magnitude stream produced by the RTI controller's md output port. For every frame of 2^HALF_FFT_WIDTH magnitude samples, the block finds the largest magnitude and the bin where it occurs, ignoring bins below a configurable guard threshold. It emits one {bin, magnitude} result per frame on an AXI-Stream master for the downstream target-tracking logic.

---
 rtl/axis_peak_bin_detector.sv | 99 +++++++++
 tb/tb_axis_peak_bin_detector.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axis_peak_bin_detector.sv
// Per-frame peak search over a magnitude stream: reports {bin, magnitude} of the
// largest eligible sample of each 2^HALF_FFT_WIDTH-sample frame on an AXI-Stream master.
module axis_peak_bin_detector #(
  parameter int MAG_WIDTH      = 16,
  parameter int HALF_FFT_WIDTH = 11
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [HALF_FFT_WIDTH-1:0]           cfg_min_bin,
  input  logic [MAG_WIDTH-1:0]                s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [HALF_FFT_WIDTH+MAG_WIDTH-1:0] m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                sts_overrun,
  output logic [15:0]                         sts_frames
);

  logic [HALF_FFT_WIDTH-1:0]           r_bin_cnt;
  logic [HALF_FFT_WIDTH-1:0]           r_min_q;
  logic [MAG_WIDTH-1:0]                r_max_mag;
  logic [HALF_FFT_WIDTH-1:0]           r_max_bin;
  logic [HALF_FFT_WIDTH+MAG_WIDTH-1:0] r_out_data;
  logic                                r_out_valid;
  logic                                r_overrun;
  logic [15:0]                         r_frames;

  logic                      w_first;
  logic                      w_last;
  logic [HALF_FFT_WIDTH-1:0] w_min_eff;
  logic                      w_elig;
  logic                      w_load;
  logic [MAG_WIDTH-1:0]      w_cand_mag;
  logic [HALF_FFT_WIDTH-1:0] w_cand_bin;

  assign w_first   = (r_bin_cnt == '0);
  assign w_last    = &r_bin_cnt;
  // Bin 0 sees the guard value presented alongside it, later bins the latched copy.
  assign w_min_eff = w_first ? cfg_min_bin : r_min_q;
  assign w_elig    = (r_bin_cnt >= w_min_eff);
  assign w_load    = s_axis_tvalid & w_last;

  // Strict compare keeps the earlier bin on ties.
  always_comb begin
    w_cand_mag = r_max_mag;
    w_cand_bin = r_max_bin;
    if (w_elig && (s_axis_tdata > r_max_mag)) begin
      w_cand_mag = s_axis_tdata;
      w_cand_bin = r_bin_cnt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bin_cnt   <= '0;
      r_min_q     <= '0;
      r_max_mag   <= '0;
      r_max_bin   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_frames    <= '0;
    end else begin
      if (s_axis_tvalid) begin
        r_bin_cnt <= r_bin_cnt + 1'b1;
        if (w_first) begin
          r_min_q <= cfg_min_bin;
        end
        if (w_last) begin
          r_max_mag <= '0;
          r_max_bin <= '0;
        end else begin
          r_max_mag <= w_cand_mag;
          r_max_bin <= w_cand_bin;
        end
      end

      // A load while the old result is being accepted is a clean hand-over, not an overrun.
      if (w_load) begin
        r_out_data  <= {w_cand_bin, w_cand_mag};
        r_out_valid <= 1'b1;
        r_frames    <= r_frames + 1'b1;
        if (r_out_valid && !m_axis_tready) begin
          r_overrun <= 1'b1;
        end
      end else if (m_axis_tready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign sts_overrun   = r_overrun;
  assign sts_frames    = r_frames;

endmodule

// File: tb/tb_axis_peak_bin_detector.sv
// Directed bench for axis_peak_bin_detector with 16-bin frames and hand-computed results.
module tb_axis_peak_bin_detector;

  localparam int MW = 16;
  localparam int HW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [HW-1:0] cfg_min_bin = '0;
  logic [MW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [HW+MW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          sts_overrun;
  logic [15:0]   sts_frames;

  int n_vec = 0;
  int n_err = 0;
  logic [HW+MW-1:0] delivered[$];
  logic [15:0] fr [16];

  axis_peak_bin_detector #(.MAG_WIDTH(MW), .HALF_FFT_WIDTH(HW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_min_bin   (cfg_min_bin),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_overrun   (sts_overrun),
    .sts_frames    (sts_frames)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) delivered.push_back(m_axis_tdata);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_sample(input logic [15:0] mag, input bit gap);
    if (gap && ($urandom_range(1) == 1)) begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 16'($urandom);
      tick();
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mag;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] mags [16], input logic [HW-1:0] cfg0,
                            input logic [HW-1:0] cfg_mid, input bit gap, input bit pre_valid,
                            input bit ready_last, input string tag);
    for (int i = 0; i < 16; i++) begin
      cfg_min_bin = (i < 4) ? cfg0 : cfg_mid;
      if (i == 15) begin
        check({tag, " tvalid before last"}, 32'(m_axis_tvalid), 32'(pre_valid));
        if (ready_last) m_axis_tready = 1'b1;
      end
      send_sample(mags[i], gap);
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic consume();
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
  endtask

  function automatic logic [31:0] peek(input int idx);
    if (delivered.size() > idx) return 32'(delivered[idx]);
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    // reset state
    repeat (2) tick();
    check("rst tready", 32'(s_axis_tready), 32'd1);
    check("rst tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst tdata", 32'(m_axis_tdata), 32'd0);
    check("rst overrun", 32'(sts_overrun), 32'd0);
    check("rst frames", 32'(sts_frames), 32'd0);
    aresetn = 1'b1;
    tick();

    // ramp frame
    for (int i = 0; i < 16; i++) fr[i] = 16'(i);
    send_frame(fr, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "ramp");
    check("ramp tvalid", 32'(m_axis_tvalid), 32'd1);
    check("ramp tdata", 32'(m_axis_tdata), 32'h0F000F);
    check("ramp frames", 32'(sts_frames), 32'd1);
    consume();
    check("ramp tvalid drop", 32'(m_axis_tvalid), 32'd0);
    check("ramp delivered n", 32'(delivered.size()), 32'd1);
    check("ramp delivered", peek(0), 32'h0F000F);

    // guard, ties, mid-frame cfg change
    for (int i = 0; i < 16; i++)
      fr[i] = (i == 1) ? 16'hFFFF : ((i == 5 || i == 9) ? 16'h0100 : 16'h0010);
    send_frame(fr, 4'd3, 4'd8, 1'b0, 1'b0, 1'b0, "guardA");
    check("guardA tdata", 32'(m_axis_tdata), 32'h050100);
    consume();
    send_frame(fr, 4'd8, 4'd8, 1'b0, 1'b0, 1'b0, "guardB");
    check("guardB tdata", 32'(m_axis_tdata), 32'h090100);
    check("guardB frames", 32'(sts_frames), 32'd3);
    consume();

    // overrun with back-to-back frames
    for (int i = 0; i < 16; i++) fr[i] = 16'(i);
    send_frame(fr, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "ovr1");
    check("ovr1 overrun", 32'(sts_overrun), 32'd0);
    for (int i = 0; i < 16; i++) fr[i] = 16'h0200 - 16'(i);
    send_frame(fr, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "ovr2");
    check("ovr2 overrun", 32'(sts_overrun), 32'd1);
    check("ovr2 tdata", 32'(m_axis_tdata), 32'h000200);
    check("ovr2 frames", 32'(sts_frames), 32'd5);
    consume();
    check("ovr sticky", 32'(sts_overrun), 32'd1);

    // asynchronous reset clears the sticky status
    aresetn = 1'b0;
    #2;
    check("rst2 overrun", 32'(sts_overrun), 32'd0);
    check("rst2 frames", 32'(sts_frames), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();
    delivered.delete();

    // handshake on the same cycle a new result loads
    for (int i = 0; i < 16; i++) fr[i] = 16'(i);
    send_frame(fr, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "simul1");
    for (int i = 0; i < 16; i++) fr[i] = (i == 7) ? 16'h1234 : 16'(i);
    send_frame(fr, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "simul2");
    check("simul tvalid", 32'(m_axis_tvalid), 32'd1);
    check("simul overrun", 32'(sts_overrun), 32'd0);
    check("simul tdata", 32'(m_axis_tdata), 32'h071234);
    check("simul frames", 32'(sts_frames), 32'd2);
    check("simul delivered n1", 32'(delivered.size()), 32'd1);
    consume();
    check("simul delivered n2", 32'(delivered.size()), 32'd2);
    check("simul first", peek(0), 32'h0F000F);
    check("simul second", peek(1), 32'h071234);

    // gapped valid, all-zero frame
    for (int i = 0; i < 16; i++) fr[i] = 16'h0000;
    send_frame(fr, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "gapzero");
    check("gapzero tvalid", 32'(m_axis_tvalid), 32'd1);
    check("gapzero tdata", 32'(m_axis_tdata), 32'h000000);
    check("gapzero frames", 32'(sts_frames), 32'd3);
    consume();

    // reset after a partial frame
    for (int i = 0; i < 7; i++) send_sample((i == 3) ? 16'hFFFF : 16'h0001, 1'b0);
    aresetn = 1'b0;
    #2;
    check("midrst tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst tdata", 32'(m_axis_tdata), 32'd0);
    check("midrst frames", 32'(sts_frames), 32'd0);
    check("midrst overrun", 32'(sts_overrun), 32'd0);
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 16; i++) fr[i] = (i == 12) ? 16'h00AA : 16'h0001;
    send_frame(fr, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "postrst");
    check("postrst tvalid", 32'(m_axis_tvalid), 32'd1);
    check("postrst tdata", 32'(m_axis_tdata), 32'h0C00AA);
    check("postrst frames", 32'(sts_frames), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
